spi_arbiter: RTL and testbench

Two-requester arbiter and transaction sequencer placed in front of `SPI_cont`. It grants the shared SPI byte engine to one of two requesters at a time and drives a dedicated active-low chip select per requester. It sequences multi-byte transfers (select setup, byte issue, receive wait, select hold, inter-frame gap) and returns each received byte to the owning requester. It connects directly to the `W_STB/W_DATA/W_READY/R_STB/R_DATA` port set of `SPI_cont`.

---
 rtl/spi_arbiter.sv | 163 ++++++++++++++++
 tb/tb_spi_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_arbiter.sv
// spi_arbiter: two-requester arbiter and frame sequencer in front of SPI_cont.
// Define SPI_ARB_TIMEOUT_EN to build the WAIT_RX receive watchdog that drives ERR.
module spi_arbiter #(
  parameter int CS_SETUP = 2,
  parameter int CS_GAP   = 4,
  parameter int TIMEOUT  = 1023
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ0,
  input  logic       REQ1,
  output logic       GNT0,
  output logic       GNT1,
  input  logic [7:0] T0_DATA,
  input  logic [7:0] T1_DATA,
  input  logic       T0_VALID,
  input  logic       T1_VALID,
  input  logic       T0_LAST,
  input  logic       T1_LAST,
  output logic       T0_READY,
  output logic       T1_READY,
  output logic [7:0] RX_DATA,
  output logic       RX0_STB,
  output logic       RX1_STB,
  output logic [1:0] CS_N,
  output logic       W_STB,
  output logic [7:0] W_DATA,
  input  logic       W_READY,
  input  logic       R_STB,
  input  logic [7:0] R_DATA,
  output logic       ERR
);
  typedef enum logic [2:0] {IDLE, SETUP, WAIT_TX, ISSUE, WAIT_RX, HOLD, GAP} state_t;
  localparam int CMAX = CS_SETUP > CS_GAP ? CS_SETUP : CS_GAP;
  localparam int CW = $clog2(CMAX + 1);
  state_t state_q, state_d;
  logic owner_q, owner_d, last_owner_q, last_owner_d, last_q, last_d;
  logic [1:0] gnt_q, gnt_d, cs_n_q, cs_n_d, rx_stb_q, rx_stb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] w_data_q, w_data_d, rx_data_q, rx_data_d;
  logic req_o, t_valid_o, t_last_o;
  logic [7:0] t_data_o;
  assign req_o     = owner_q ? REQ1 : REQ0;
  assign t_valid_o = owner_q ? T1_VALID : T0_VALID;
  assign t_last_o  = owner_q ? T1_LAST : T0_LAST;
  assign t_data_o  = owner_q ? T1_DATA : T0_DATA;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_q, to_d;
  logic err_q, err_d;
  assign ERR = err_q;
`else
  assign ERR = TIMEOUT < 0;
`endif
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    last_d       = last_q;
    gnt_d        = gnt_q;
    cs_n_d       = cs_n_q;
    cnt_d        = cnt_q;
    w_data_d     = w_data_q;
    rx_data_d    = rx_data_q;
    rx_stb_d     = '0;
`ifdef SPI_ARB_TIMEOUT_EN
    to_d         = '0;
    err_d        = 1'b0;
`endif
    case (state_q)
      IDLE: if (REQ0 | REQ1) begin
        owner_d      = (REQ0 & REQ1) ? ~last_owner_q : REQ1;
        last_owner_d = owner_d;
        gnt_d        = owner_d ? 2'b10 : 2'b01;
        cs_n_d       = ~gnt_d;
        cnt_d        = '0;
        state_d      = SETUP;
      end
      SETUP: begin
        cnt_d   = cnt_q == CW'(CS_SETUP - 1) ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == CW'(CS_SETUP - 1) ? WAIT_TX : SETUP;
      end
      WAIT_TX: if (!req_o) begin
        cnt_d   = '0;
        state_d = HOLD;
      end else if (t_valid_o && W_READY) begin
        w_data_d = t_data_o;
        last_d   = t_last_o;
        state_d  = ISSUE;
      end
      ISSUE: state_d = WAIT_RX;
      WAIT_RX: begin
        if (R_STB) begin
          rx_data_d = R_DATA;
          rx_stb_d  = owner_q ? 2'b10 : 2'b01;
          cnt_d     = '0;
          state_d   = last_q ? HOLD : WAIT_TX;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (to_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = HOLD;
        end else to_d = to_q + 1'b1;
`endif
      end
      HOLD: if (cnt_q == CW'(CS_SETUP)) begin
        cs_n_d  = 2'b11;
        gnt_d   = 2'b00;
        cnt_d   = '0;
        state_d = GAP;
      end else cnt_d = cnt_q + 1'b1;
      GAP: begin
        cnt_d   = cnt_q == CW'(CS_GAP - 1) ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == CW'(CS_GAP - 1) ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      last_q       <= 1'b0;
      gnt_q        <= '0;
      cs_n_q       <= 2'b11;
      cnt_q        <= '0;
      w_data_q     <= '0;
      rx_data_q    <= '0;
      rx_stb_q     <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      to_q         <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      last_q       <= last_d;
      gnt_q        <= gnt_d;
      cs_n_q       <= cs_n_d;
      cnt_q        <= cnt_d;
      w_data_q     <= w_data_d;
      rx_data_q    <= rx_data_d;
      rx_stb_q     <= rx_stb_d;
`ifdef SPI_ARB_TIMEOUT_EN
      to_q         <= to_d;
      err_q        <= err_d;
`endif
    end
  end
  assign GNT0     = gnt_q[0];
  assign GNT1     = gnt_q[1];
  assign CS_N     = cs_n_q;
  assign W_STB    = state_q == ISSUE;
  assign W_DATA   = w_data_q;
  assign T0_READY = W_STB & ~owner_q;
  assign T1_READY = W_STB & owner_q;
  assign RX_DATA  = rx_data_q;
  assign RX0_STB  = rx_stb_q[0];
  assign RX1_STB  = rx_stb_q[1];
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: table-driven single frame plus hand sequences for contention, aborts,
// backpressure, mid-frame reset and (with SPI_ARB_TIMEOUT_EN) the receive watchdog.
module tb_spi_arbiter;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO = 50;
`else
  localparam int TO = 1023;
`endif
  localparam int S_WSTB = 0, S_RX0 = 1, S_RX1 = 2, S_IDLE = 3;
  logic clk = 1'b0, rst;
  logic [1:0] req, tv, tl;
  logic [7:0] td [2];
  logic w_ready, r_stb;
  logic [7:0] r_data;
  logic gnt0, gnt1, tr0, tr1, rx0, rx1, w_stb, err;
  logic [1:0] cs_n, trdy;
  logic [7:0] w_data, rx_data;
  int checks = 0, errors = 0;
  logic auto_en, rsp_en;
  int rsp_cnt, bc[2], nb[2], cs_both_low, err_cnt;
  logic [1:0] gnt_prev;

  spi_arbiter #(.CS_SETUP(2), .CS_GAP(4), .TIMEOUT(TO)) dut (
    .CLK(clk), .RST(rst), .REQ0(req[0]), .REQ1(req[1]), .GNT0(gnt0), .GNT1(gnt1),
    .T0_DATA(td[0]), .T1_DATA(td[1]), .T0_VALID(tv[0]), .T1_VALID(tv[1]),
    .T0_LAST(tl[0]), .T1_LAST(tl[1]), .T0_READY(tr0), .T1_READY(tr1),
    .RX_DATA(rx_data), .RX0_STB(rx0), .RX1_STB(rx1), .CS_N(cs_n),
    .W_STB(w_stb), .W_DATA(w_data), .W_READY(w_ready), .R_STB(r_stb), .R_DATA(r_data),
    .ERR(err)
  );
  assign trdy = {tr1, tr0};
  always #5 clk = ~clk;

  typedef struct {
    logic r0, v0;
    logic [7:0] d0;
    logic l0, wr, rs;
    logic [7:0] rd;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [16];

  function automatic logic [31:0] pk(input logic e, input logic [1:0] g, input logic [1:0] c,
      input logic ws, input logic [1:0] tr, input logic [1:0] rs, input logic [7:0] wd,
      input logic [7:0] rd);
    return {6'b0, e, g, c, ws, tr, rs, wd, rd};
  endfunction

  function automatic logic [31:0] outs();
    return {6'b0, err, gnt1, gnt0, cs_n, w_stb, tr1, tr0, rx1, rx0, w_data, rx_data};
  endfunction

  function automatic logic sig(input int sel);
    case (sel)
      S_WSTB: return w_stb;
      S_RX0:  return rx0;
      S_RX1:  return rx1;
      default: return cs_n == 2'b11;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock; in auto mode also runs the requester and SPI_cont models.
  task automatic tick();
    @(posedge clk);
    #1;
    if (cs_n == 2'b00) cs_both_low++;
    if (err) err_cnt++;
    if (auto_en) begin
      r_stb = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          r_stb  = 1'b1;
          r_data = ~w_data;
        end
      end else if (w_stb && rsp_en) rsp_cnt = 2;
      for (int i = 0; i < 2; i++) begin
        if (trdy[i]) bc[i]++;
        if (gnt_prev[i] && !(i == 0 ? gnt0 : gnt1)) bc[i] = 0;
        tv[i] = req[i] && bc[i] < nb[i];
        tl[i] = bc[i] == nb[i] - 1;
        td[i] = 8'(16 * i + bc[i] + 1);
      end
    end
    gnt_prev = {gnt1, gnt0};
  endtask

  task automatic wait_until(input int sel, input int lim, input string nm);
    int n = 0;
    while (!sig(sel) && n < lim) begin
      tick();
      n++;
    end
    checks++;
    if (!sig(sel)) begin
      errors++;
      $display("FAIL %s: event not seen within %0d cycles", nm, lim);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tv = '0;
    tl = '0;
    r_stb = 1'b0;
    rsp_cnt = 0;
    bc = '{0, 0};
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int ws, rxc;
    logic [1:0] c3, c4;
    tbl[0]  = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 8'h00, pk(1'b0, 2'b01, 2'b10, 1'b0, 2'b00, 2'b00, 8'h00, 8'h00)};
    tbl[1]  = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 8'h77, pk(1'b0, 2'b01, 2'b10, 1'b0, 2'b00, 2'b00, 8'h00, 8'h00)};
    tbl[2]  = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 8'h00, pk(1'b0, 2'b01, 2'b10, 1'b0, 2'b00, 2'b00, 8'h00, 8'h00)};
    tbl[3]  = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 8'h00, pk(1'b0, 2'b01, 2'b10, 1'b1, 2'b01, 2'b00, 8'h55, 8'h00)};
    tbl[4]  = '{1'b1, 1'b1, 8'hA3, 1'b1, 1'b1, 1'b0, 8'h00, pk(1'b0, 2'b01, 2'b10, 1'b0, 2'b00, 2'b00, 8'h55, 8'h00)};
    tbl[5]  = '{1'b1, 1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 8'hA9, pk(1'b0, 2'b01, 2'b10, 1'b0, 2'b00, 2'b01, 8'h55, 8'hA9)};
    tbl[6]  = '{1'b1, 1'b1, 8'hA3, 1'b1, 1'b1, 1'b0, 8'h00, pk(1'b0, 2'b01, 2'b10, 1'b1, 2'b01, 2'b00, 8'hA3, 8'hA9)};
    tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, pk(1'b0, 2'b01, 2'b10, 1'b0, 2'b00, 2'b00, 8'hA3, 8'hA9)};
    tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hC3, pk(1'b0, 2'b01, 2'b10, 1'b0, 2'b00, 2'b01, 8'hA3, 8'hC3)};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h66, pk(1'b0, 2'b01, 2'b10, 1'b0, 2'b00, 2'b00, 8'hA3, 8'hC3)};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, pk(1'b0, 2'b01, 2'b10, 1'b0, 2'b00, 2'b00, 8'hA3, 8'hC3)};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, pk(1'b0, 2'b00, 2'b11, 1'b0, 2'b00, 2'b00, 8'hA3, 8'hC3)};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hEE, pk(1'b0, 2'b00, 2'b11, 1'b0, 2'b00, 2'b00, 8'hA3, 8'hC3)};
    for (int i = 13; i < 16; i++)
      tbl[i] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, pk(1'b0, 2'b00, 2'b11, 1'b0, 2'b00, 2'b00, 8'hA3, 8'hC3)};
    auto_en = 1'b0;
    rsp_en = 1'b1;
    nb = '{0, 0};
    cs_both_low = 0;
    err_cnt = 0;
    gnt_prev = '0;
    w_ready = 1'b1;
    r_data = '0;
    td[0] = '0;
    td[1] = '0;
    do_reset();
    rst = 1'b1;
    tick();
    chk("reset state", outs(), pk(1'b0, 2'b00, 2'b11, 1'b0, 2'b00, 2'b00, 8'h00, 8'h00));
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      req = {1'b0, tbl[i].r0};
      tv = {1'b0, tbl[i].v0};
      td[0] = tbl[i].d0;
      tl = {1'b0, tbl[i].l0};
      w_ready = tbl[i].wr;
      r_stb = tbl[i].rs;
      r_data = tbl[i].rd;
      tick();
      chk($sformatf("frame vec%0d", i), outs(), tbl[i].exp);
    end

    // Contention: both requesters keep asking; grants must alternate from requester 0.
    do_reset();
    auto_en = 1'b1;
    nb = '{2, 2};
    req = 2'b11;
    begin
      int g = 0, hi = 0, mg = 1000, n = 0;
      logic [1:0] pg = 2'b00, cur;
      logic [1:0] own [3] = '{2'b00, 2'b00, 2'b00};
      while (g < 3 && n < 300) begin
        tick();
        n++;
        cur = {gnt1, gnt0};
        if (cur != 2'b00 && pg == 2'b00) begin
          if (g > 0 && hi < mg) mg = hi;
          own[g] = cur;
          g++;
        end
        hi = cs_n == 2'b11 ? hi + 1 : 0;
        pg = cur;
      end
      chk("contention grant count", 32'(g), 32'd3);
      chk("contention grant 1", {30'b0, own[0]}, 32'h1);
      chk("contention grant 2", {30'b0, own[1]}, 32'h2);
      chk("contention grant 3", {30'b0, own[2]}, 32'h1);
      chk("contention cs gap >= CS_GAP", {31'b0, mg >= 4}, 32'h1);
    end
    req = 2'b00;
    wait_until(S_IDLE, 60, "contention release");
    repeat (8) tick();

    // Abort between bytes: REQ1 drops in WAIT_TX after the first of three bytes.
    do_reset();
    nb[1] = 3;
    req = 2'b10;
    wait_until(S_RX1, 60, "abort first rx");
    req = 2'b00;
    ws = 0;
    c3 = '0;
    c4 = '0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (w_stb) ws++;
      if (k == 3) c3 = cs_n;
      if (k == 4) c4 = cs_n;
    end
    chk("abort no w_stb", 32'(ws), 32'd0);
    chk("abort cs held", {30'b0, c3}, 32'h1);
    chk("abort cs release", {30'b0, c4}, 32'h3);
    repeat (8) tick();

    // REQ1 drop while a byte is in flight must still deliver RX1_STB.
    nb[1] = 3;
    req = 2'b10;
    wait_until(S_WSTB, 40, "drop-in-rx issue");
    req = 2'b00;
    wait_until(S_RX1, 10, "drop-in-rx rx1_stb");
    chk("drop-in-rx data", {24'b0, rx_data}, 32'hEE);
    ws = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (w_stb) ws++;
    end
    chk("drop-in-rx no further w_stb", 32'(ws), 32'd0);
    wait_until(S_IDLE, 20, "drop-in-rx release");
    repeat (6) tick();

    // Backpressure: W_READY low for 20 cycles.
    do_reset();
    w_ready = 1'b0;
    nb[0] = 1;
    req = 2'b01;
    ws = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (w_stb || tr0) ws++;
    end
    chk("backpressure no issue", 32'(ws), 32'd0);
    w_ready = 1'b1;
    tick();
    chk("backpressure issue after ready", {23'b0, w_stb, w_data}, {23'b0, 1'b1, 8'h01});
    wait_until(S_IDLE, 40, "backpressure release");
    req = 2'b00;
    repeat (6) tick();

    // Reset while waiting for the receive byte.
    do_reset();
    rsp_en = 1'b0;
    nb[0] = 2;
    req = 2'b01;
    wait_until(S_WSTB, 20, "reset-mid issue");
    tick();
    auto_en = 1'b0;
    rst = 1'b1;
    r_stb = 1'b1;
    r_data = 8'h5A;
    tick();
    chk("reset-mid cs/gnt", {28'b0, gnt1, gnt0, cs_n}, 32'h3);
    rxc = rx0 | rx1;
    rst = 1'b0;
    req = 2'b00;
    tv = 2'b00;
    for (int k = 0; k < 5; k++) begin
      tick();
      r_stb = 1'b0;
      rxc += int'(rx0 | rx1);
    end
    chk("reset-mid no rx_stb", 32'(rxc), 32'd0);
    chk("reset-mid rx_data", {24'b0, rx_data}, 32'h0);

`ifdef SPI_ARB_TIMEOUT_EN
    do_reset();
    auto_en = 1'b1;
    rsp_en = 1'b0;
    nb[0] = 1;
    req = 2'b01;
    wait_until(S_WSTB, 20, "timeout issue");
    begin
      logic [3:0] e;
      logic [1:0] cs53, cs54;
      e = '0;
      rxc = 0;
      for (int k = 1; k <= 54; k++) begin
        tick();
        rxc += int'(rx0 | rx1);
        if (k == 50) e[0] = err;
        if (k == 51) e[1] = err;
        if (k == 52) e[2] = err;
        if (k == 53) cs53 = cs_n;
        if (k == 54) cs54 = cs_n;
      end
      chk("timeout err pulse", {29'b0, e[2:0]}, 32'h2);
      chk("timeout no rx_stb", 32'(rxc), 32'd0);
      chk("timeout release", {28'b0, cs53, cs54}, 32'hB);
    end
    req = 2'b00;
    repeat (8) tick();
    chk("err pulse count", 32'(err_cnt), 32'd1);
`else
    chk("err stays low", 32'(err_cnt), 32'd0);
`endif
    chk("cs never both low", 32'(cs_both_low), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
